// File: rtl/serial_subtractor7bit.sv
// rtl/serial_subtractor7bit.sv - bit-serial 7-bit unsigned subtractor, LSB first
// One difference bit per clock; start/busy/done handshake around an IDLE/RUN/DONE FSM.
module serial_subtractor7bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] in1,
  input  logic [6:0] in2,
  output logic       busy,
  output logic       done,
  output logic [6:0] diff,
  output logic       bout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_S
  } state_t;

  state_t     state;
  logic [6:0] a;
  logic [6:0] b;
  logic       br;
  logic [2:0] cnt;
  logic       d;
  logic       br_next;

  // Full-subtractor cell on the current LSBs and the rippled borrow
  always_comb begin
    d       = a[0] ^ b[0] ^ br;
    br_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= 7'd0;
      b     <= 7'd0;
      br    <= 1'b0;
      cnt   <= 3'd0;
      diff  <= 7'd0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a     <= in1;
            b     <= in2;
            br    <= 1'b0;
            cnt   <= 3'd0;
            diff  <= 7'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a    <= {1'b0, a[6:1]};
          b    <= {1'b0, b[6:1]};
          br   <= br_next;
          diff <= {d, diff[6:1]};
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_S;
          end
        end
        DONE_S: begin
          done <= 1'b0;
          // diff/bout stay intact on a back-to-back accept until RUN shifts overwrite them
          if (start) begin
            a     <= in1;
            b     <= in2;
            br    <= 1'b0;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor7bit.sv
// tb/tb_serial_subtractor7bit.sv - self-checking bench for serial_subtractor7bit
// Reference model is plain integer subtraction modulo 128.
module tb_serial_subtractor7bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] in1;
  logic [6:0] in2;
  logic       busy;
  logic       done;
  logic [6:0] diff;
  logic       bout;

  int checks;
  int errors;

  serial_subtractor7bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ref_diff(input int x, input int y);
    return 7'((x - y + 128) % 128);
  endfunction

  function automatic logic ref_bout(input int x, input int y);
    return (x < y);
  endfunction

  task automatic do_op(input int x, input int y, input string tag);
    int lat;
    in1   = 7'(x);
    in2   = 7'(y);
    start = 1'b1;
    step();
    start = 1'b0;
    in1   = 7'($urandom);
    in2   = 7'($urandom);
    lat   = 1;
    while (!done && lat < 20) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b exp 1", tag, lat, busy);
      end
      step();
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency got %0d exp 8", tag, lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_with_done got %b exp 0", tag, busy);
    end
    checks++;
    if (diff !== ref_diff(x, y)) begin
      errors++;
      $display("FAIL %s diff %0d-%0d got %0d exp %0d", tag, x, y, diff, ref_diff(x, y));
    end
    checks++;
    if (bout !== ref_bout(x, y)) begin
      errors++;
      $display("FAIL %s bout %0d-%0d got %b exp %b", tag, x, y, bout, ref_bout(x, y));
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    in1   = 7'd0;
    in2   = 7'd0;
    step();
    step();
    checks++;
    if ({busy, done, diff, bout} !== 10'd0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b diff=%0d bout=%b exp all 0", busy, done, diff, bout);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int ops[5][2] = '{'{5, 3}, '{3, 5}, '{0, 0}, '{127, 0}, '{0, 127}};
    foreach (ops[i]) begin
      do_op(ops[i][0], ops[i][1], "basic");
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (done !== 1'b0 || diff !== ref_diff(ops[i][0], ops[i][1]) ||
            bout !== ref_bout(ops[i][0], ops[i][1])) begin
          errors++;
          $display("FAIL hold got done=%b diff=%0d bout=%b exp 0 %0d %b", done, diff, bout,
                   ref_diff(ops[i][0], ops[i][1]), ref_bout(ops[i][0], ops[i][1]));
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [6:0] got_diff;
    logic got_bout;
    ndone    = 0;
    got_diff = 7'd0;
    got_bout = 1'b0;
    in1      = 7'd10;
    in2      = 7'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    in1   = 7'd1;
    in2   = 7'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in1 = 7'($urandom);
      in2 = 7'($urandom);
      if (done) begin
        ndone++;
        got_diff = diff;
        got_bout = bout;
      end
      step();
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start done_count got %0d exp 1", ndone);
    end
    checks++;
    if (got_diff !== 7'd6 || got_bout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result got %0d/%b exp 6/0", got_diff, got_bout);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in1   = 7'd20;
    in2   = 7'd7;
    start = 1'b1;
    step();
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 8 || diff !== 7'd13 || bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d diff=%0d bout=%b exp 8 13 0", lat, diff, bout);
    end
    in1 = 7'd7;
    in2 = 7'd20;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle got busy=%b done=%b exp 1 0", busy, done);
    end
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 8 || diff !== 7'd115 || bout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d diff=%0d bout=%b exp 8 115 1", lat, diff, bout);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int ndone;
    ndone = 0;
    in1   = 7'd100;
    in2   = 7'd50;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, diff, bout} !== 10'd0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b diff=%0d bout=%b exp all 0", busy, done, diff, bout);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles exp 0", ndone);
    end
    do_op(9, 9, "after_reset");
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      do_op(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), "random");
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
